mem_port_arbiter: RTL and testbench

Sequences and shares the single-port unified instruction/data memory between the fetch stage and the load/store datapath. Data accesses use the control unit's 2-bit size encoding: 01 word, 10 half, 11 byte, 00 none. The block performs store byte-lane steering and load extraction with sign/zero extension. It also flags misaligned accesses and memory timeouts, and drives a stall to the core while a transaction is in flight.

---
 rtl/mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between instruction
// fetch and the load/store datapath. Data wins over fetch in IDLE. Stores get
// byte-lane steering and loads get extraction with sign or zero extension.
// Misaligned accesses and memory timeouts are reported, and the core is stalled
// while an access is in flight.
// The lane logic assumes DATA_WIDTH is 32, which gives four byte lanes.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  stall_o
);

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] NOP_INSN    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] WORD_MASK   = ~DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_addr_q, if_addr_d;

  logic                  d_rvalid_q, d_rvalid_d;
  logic                  d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;

  logic                  d_valid;
  logic                  d_misaligned;
  logic                  busy;
  logic                  wait_expired;
  logic [3:0]            store_be;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_data;

  // A data request of size 00 is treated as no request at all.
  assign d_valid = d_req_i && (d_size_i != SZ_NONE);

  // Half accesses need an even address and word accesses need a 4-byte aligned
  // address. Byte accesses can never be misaligned.
  assign d_misaligned = ((d_size_i == SZ_HALF) && d_addr_i[0]) ||
                        ((d_size_i == SZ_WORD) && (d_addr_i[1:0] != 2'b00));

  assign busy = (state_q != IDLE);

  // Timeout fires only after TIMEOUT wait cycles without ready. Ready in the
  // last allowed cycle still completes the access normally.
  assign wait_expired = busy && !mem_ready_i && ((cnt_q + 8'd1) == TIMEOUT_CNT);

  // Registers the state, the wait counter, the captured request and the response pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_addr_q   <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_addr_q   <= if_addr_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then wait for ready or the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_valid) begin
          if (!d_misaligned) begin
            state_d = DATA;
          end
        end else if (if_req_i) begin
          state_d = FETCH;
        end
      end
      DATA, FETCH: begin
        if (mem_ready_i || wait_expired) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Store lane steering: byte enables and replicated data from the captured request.
  always_comb begin
    store_be   = 4'b1111;
    store_data = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {(DATA_WIDTH/8){wdata_q[7:0]}};
      end
      SZ_HALF: begin
        store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {(DATA_WIDTH/16){wdata_q[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  // Load extraction: move the addressed lane down to bit 0, then sign- or zero-extend it.
  always_comb begin
    load_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};
    load_data    = load_shifted;
    case (size_q)
      SZ_BYTE: load_data = {{(DATA_WIDTH-8){!uns_q && load_shifted[7]}}, load_shifted[7:0]};
      SZ_HALF: load_data = {{(DATA_WIDTH-16){!uns_q && load_shifted[15]}}, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  // Output logic: grants in IDLE, memory request fields while a transaction is in flight.
  always_comb begin
    d_gnt_o     = 1'b0;
    if_gnt_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = addr_q & WORD_MASK;
    mem_wdata_o = store_data;
    case (state_q)
      IDLE: begin
        d_gnt_o  = rst_n_i && d_valid;
        if_gnt_o = rst_n_i && !d_valid && if_req_i;
      end
      DATA: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
        mem_be_o  = we_q ? store_be : 4'b1111;
      end
      FETCH: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'b1111;
        mem_addr_o = if_addr_q & WORD_MASK;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
    stall_o = busy || d_gnt_o || if_gnt_o;
  end

  // Capture granted requests and build next-cycle rvalid/err pulses with their data.
  always_comb begin
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_addr_d   = if_addr_q;
    d_rvalid_d  = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;

    if (d_gnt_o) begin
      we_d    = d_we_i;
      size_d  = d_size_i;
      uns_d   = d_unsigned_i;
      addr_d  = d_addr_i;
      wdata_d = d_wdata_i;
      d_err_d = d_misaligned;
    end

    if (if_gnt_o) begin
      if_addr_d = if_addr_i;
    end

    if (state_q == DATA) begin
      if (mem_ready_i) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = we_q ? '0 : load_data;
      end else if (wait_expired) begin
        d_err_d = 1'b1;
      end
    end

    if (state_q == FETCH) begin
      if (mem_ready_i) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata_i;
      end else if (wait_expired) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = NOP_INSN;
      end
    end
  end

  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a behavioural model of lane steering, load extension and timing.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int TO = 6;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          if_req_i;
  logic [DW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [1:0]    d_size_i;
  logic          d_unsigned_i;
  logic [DW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          d_err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          stall_o;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_unsigned_i(d_unsigned_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic bit refMisaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == SZ_HALF) return (addr % 2) != 0;
    if (size == SZ_WORD) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] refBe(input logic we, input logic [1:0] size, input logic [31:0] addr);
    if (!we) return 4'hF;
    if (size == SZ_BYTE) return 4'(1 << (addr % 4));
    if (size == SZ_HALF) return 4'(3 << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] refWdata(input logic [1:0] size, input logic [31:0] w);
    if (size == SZ_BYTE) return (w & 32'hFF) * 32'h0101_0101;
    if (size == SZ_HALF) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] word);
    int nbits;
    logic [31:0] v;
    logic [31:0] mask;
    nbits = (size == SZ_BYTE) ? 8 : (size == SZ_HALF) ? 16 : 32;
    v = word >> (8 * (addr % 4));
    mask = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
    v = v & mask;
    if (!uns && nbits < 32 && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  // Runs one complete fetch or data transaction and checks it against the model.
  task automatic applyStimulus(input bit isFetch, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] memWord, input int waitCycles);
    bit misal;
    bit timedOut;
    int reqCycles;
    bit reqOk;
    bit stallOk;
    bit fieldsOk;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    logic        expWe;
    misal     = !isFetch && refMisaligned(size, addr);
    timedOut  = (waitCycles >= TO);
    reqCycles = timedOut ? TO : waitCycles + 1;
    expAddr   = addr - (addr % 4);
    expBe     = isFetch ? 4'hF : refBe(we, size, addr);
    expWe     = !isFetch && we;
    expWdata  = refWdata(size, wdata);

    mem_ready_i = 1'b0;
    if (isFetch) begin
      if_req_i  = 1'b1;
      if_addr_i = addr;
    end else begin
      d_req_i      = 1'b1;
      d_we_i       = we;
      d_size_i     = size;
      d_unsigned_i = uns;
      d_addr_i     = addr;
      d_wdata_i    = wdata;
    end
    #1;
    if (isFetch) checkOutput("if_gnt", if_gnt_o, 1);
    else         checkOutput("d_gnt", d_gnt_o, 1);
    checkOutput("stall_grant", stall_o, 1);

    if (misal) begin
      @(posedge clk_i); #1;
      checkOutput("misal_err", d_err_o, 1);
      checkOutput("misal_no_req", mem_req_o, 0);
      checkOutput("misal_no_rvalid", d_rvalid_o, 0);
      d_req_i = 1'b0;
    end else begin
      reqOk    = 1'b1;
      stallOk  = 1'b1;
      fieldsOk = 1'b1;
      for (int k = 0; k < reqCycles; k++) begin
        @(posedge clk_i); #1;
        if (mem_req_o !== 1'b1) reqOk = 1'b0;
        if (d_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || d_err_o !== 1'b0) reqOk = 1'b0;
        if (stall_o !== 1'b1) stallOk = 1'b0;
        if (mem_addr_o !== expAddr || mem_be_o !== expBe || mem_we_o !== expWe) fieldsOk = 1'b0;
        if (expWe && mem_wdata_o !== expWdata) fieldsOk = 1'b0;
        mem_ready_i = (k == waitCycles);
        mem_rdata_i = (k == waitCycles) ? memWord : $urandom();
      end
      checkOutput("mem_req_held", 32'(reqOk), 1);
      checkOutput("stall_held", 32'(stallOk), 1);
      checkOutput("mem_fields", 32'(fieldsOk), 1);
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      checkOutput("req_dropped", mem_req_o, 0);
      if (isFetch) begin
        checkOutput("if_rvalid", if_rvalid_o, 1);
        checkOutput("if_rdata", if_rdata_o, timedOut ? 32'h0000_0013 : memWord);
        if_req_i = 1'b0;
      end else if (timedOut) begin
        checkOutput("d_err_timeout", d_err_o, 1);
        checkOutput("no_rvalid_timeout", d_rvalid_o, 0);
        d_req_i = 1'b0;
      end else begin
        checkOutput("d_rvalid", d_rvalid_o, 1);
        checkOutput("d_rdata", d_rdata_o, we ? 32'h0 : refLoad(size, uns, addr, memWord));
        checkOutput("d_no_err", d_err_o, 0);
        d_req_i = 1'b0;
      end
    end
    @(posedge clk_i); #1;
    checkOutput("pulse_end", {d_rvalid_o, d_err_o, if_rvalid_o}, 0);
  endtask

  // Memory asserting ready while nothing is in flight must have no effect.
  task automatic idleGap(input int n);
    mem_ready_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      mem_rdata_i = $urandom();
      @(posedge clk_i); #1;
      checkOutput("idle_ready_ignored", {mem_req_o, d_rvalid_o, d_err_o, if_rvalid_o}, 0);
    end
    mem_ready_i = 1'b0;
  endtask

  // Time-out guard so the run always finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, contention, random traffic, reset mid-flight.
  initial begin
    bit          rFetch;
    logic [1:0]  rSize;
    logic [31:0] rAddr;
    int          r;
    int          rWait;
    bit          quietOk;

    rst_n_i      = 1'b0;
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    d_req_i      = 1'b0;
    d_we_i       = 1'b0;
    d_size_i     = SZ_NONE;
    d_unsigned_i = 1'b0;
    d_addr_i     = '0;
    d_wdata_i    = '0;
    mem_rdata_i  = '0;
    mem_ready_i  = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_mem_req", mem_req_o, 0);
    checkOutput("rst_mem_we", mem_we_o, 0);
    checkOutput("rst_mem_be", mem_be_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 0);
    checkOutput("rst_pulses", {d_rvalid_o, d_err_o, if_rvalid_o, d_gnt_o, if_gnt_o}, 0);
    checkOutput("rst_stall", stall_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    applyStimulus(0, 0, SZ_WORD, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    applyStimulus(0, 0, SZ_BYTE, 0, 32'h103, 32'h0, 32'h8081_F2F3, 0);
    applyStimulus(0, 0, SZ_BYTE, 1, 32'h103, 32'h0, 32'h8081_F2F3, 1);
    applyStimulus(0, 0, SZ_HALF, 0, 32'h102, 32'h0, 32'h8081_F2F3, 0);
    applyStimulus(0, 0, SZ_HALF, 1, 32'h100, 32'h0, 32'h8081_F2F3, 0);
    applyStimulus(0, 1, SZ_BYTE, 0, 32'h201, 32'h1122_3344, 32'h0, 0);
    applyStimulus(0, 1, SZ_HALF, 0, 32'h202, 32'h1122_3344, 32'h0, 0);
    applyStimulus(0, 1, SZ_WORD, 0, 32'h200, 32'h1122_3344, 32'h0, 1);
    applyStimulus(0, 0, SZ_WORD, 0, 32'h104, 32'h0, 32'h0BAD_F00D, TO - 1);
    applyStimulus(0, 0, SZ_WORD, 0, 32'h108, 32'h0, 32'h0, 100);
    applyStimulus(0, 1, SZ_HALF, 0, 32'h201, 32'h1122_3344, 32'h0, 0);
    applyStimulus(0, 0, SZ_WORD, 0, 32'h102, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, SZ_WORD, 0, 32'h400, 32'h0, 32'h0050_0093, 0);
    applyStimulus(1, 0, SZ_WORD, 0, 32'h404, 32'h0, 32'h0, 100);

    d_req_i  = 1'b1;
    d_size_i = SZ_NONE;
    #1;
    checkOutput("size00_no_gnt", d_gnt_o, 0);
    checkOutput("size00_no_stall", stall_o, 0);
    @(posedge clk_i); #1;
    checkOutput("size00_no_req", mem_req_o, 0);
    d_req_i = 1'b0;

    d_req_i      = 1'b1;
    d_we_i       = 1'b0;
    d_size_i     = SZ_WORD;
    d_unsigned_i = 1'b0;
    d_addr_i     = 32'h300;
    if_req_i     = 1'b1;
    if_addr_i    = 32'h408;
    #1;
    checkOutput("cont_d_gnt", d_gnt_o, 1);
    checkOutput("cont_if_wait", if_gnt_o, 0);
    @(posedge clk_i); #1;
    checkOutput("cont_if_wait_busy", if_gnt_o, 0);
    checkOutput("cont_d_addr", mem_addr_o, 32'h300);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    checkOutput("cont_d_rvalid", d_rvalid_o, 1);
    checkOutput("cont_d_rdata", d_rdata_o, 32'hCAFE_F00D);
    d_req_i = 1'b0;
    #1;
    checkOutput("cont_if_gnt", if_gnt_o, 1);
    @(posedge clk_i); #1;
    checkOutput("cont_if_addr", mem_addr_o, 32'h408);
    checkOutput("cont_if_req", mem_req_o, 1);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    checkOutput("cont_if_rvalid", if_rvalid_o, 1);
    checkOutput("cont_if_rdata", if_rdata_o, 32'h1234_5678);
    if_req_i = 1'b0;
    idleGap(2);

    for (int i = 0; i < 40; i++) begin
      rFetch = ($urandom_range(0, 3) == 0);
      rSize  = 2'($urandom_range(1, 3));
      rAddr  = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
      if (!rFetch) rAddr = rAddr + 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      rWait = (r < 7) ? (r % 3) : (r == 7) ? TO - 1 : (r == 8) ? TO : 50;
      applyStimulus(rFetch, 1'($urandom_range(0, 1)), rSize, 1'($urandom_range(0, 1)),
                    rAddr, $urandom(), $urandom(), rWait);
      if ($urandom_range(0, 3) == 0) idleGap(1);
    end

    d_req_i      = 1'b1;
    d_we_i       = 1'b0;
    d_size_i     = SZ_WORD;
    d_addr_i     = 32'h500;
    mem_ready_i  = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("midrst_in_data", mem_req_o, 1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    d_req_i = 1'b0;
    #1;
    checkOutput("midrst_req_low", mem_req_o, 0);
    checkOutput("midrst_stall_low", stall_o, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    mem_ready_i = 1'b1;
    quietOk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      if ({d_rvalid_o, d_err_o, if_rvalid_o, mem_req_o} !== 4'b0000) quietOk = 1'b0;
    end
    mem_ready_i = 1'b0;
    checkOutput("midrst_no_stale", 32'(quietOk), 1);
    applyStimulus(1, 0, SZ_WORD, 0, 32'h600, 32'h0, 32'h0000_0513, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
